p405s_icu_dp_fetchbuf: RTL and testbench
========================================

# p405s_icu_dp_fetchBuf

Parametrised, enable-gated register buffer for the ICU datapath. It holds up to DEPTH entries of WIDTH bits in a first-in/first-out queue, with occupancy reporting, flush and sticky overflow detection. It sits between the ICU fill/fetch datapath and the instruction-issue side and replaces single-entry enable registers wherever more than one word must be staged.

## Interface
- WIDTH, 32, data width of each entry (≥1).
- DEPTH, 4, number of entries; power of two, ≥2.
- CW, clog2(DEPTH+1), width of the Count output (derived, not overridden).
- CB  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- D  in  [0:WIDTH-1]  write data.
- E1  in  1  push request; D is written when the push is accepted.
- Rd  in  1  pop request; the head entry is removed when the pop is accepted.
- Flush  in  1  synchronous clear of all entries and pointers.
- L2  out  [0:WIDTH-1]  head entry data; all zeros when empty.
- Valid  out  1  buffer non-empty (Count ≠ 0).
- Full  out  1  Count == DEPTH.
- Count  out  [CW-1:0]  current occupancy, 0..DEPTH.
- Ovf  out  1  sticky overflow flag.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wp, read pointer rp, each log2(DEPTH) bits wide. Pointers wrap naturally modulo DEPTH. Occupancy is held in an explicit counter, Count.
- Pop accepted (pa) = Rd & Valid. A pop on empty is ignored with no state change.
- Push accepted (wa) = E1 & (~Full | pa). A push on full is accepted only when a pop is also accepted in the same cycle.
- Dropped push = E1 & Full & ~pa. The entry is not written and Ovf is set to 1 on that edge. Ovf stays 1 until Flush or Reset.
- On wa: mem[wp] ← D, wp ← wp+1.
- On pa: rp ← rp+1.
- Count update:
  - wa & ~pa: +1
  - pa & ~wa: −1
  - both or neither: unchanged
- Simultaneous push and pop at Count==1: the head advances to the newly written entry and Count stays 1.
- Flush has priority over E1 and Rd in the same cycle. It sets wp=rp=0, Count=0 and Ovf=0. Array contents need not be cleared, but L2 must read zeros while empty.
- L2 = mem[rp] when Valid, else 0. L2 is combinational from registered state only; there is no combinational path from D, E1 or Rd to any output.
- There is no state machine beyond the pointers and counter. The states are effectively EMPTY (Count=0), PARTIAL and FULL (Count=DEPTH), and the transitions follow the Count rules above.

## Timing
- Reset (asynchronous, while asserted and immediately after release) drives:
  - wp=rp=0, Count=0, Valid=0, Full=0, Ovf=0
  - L2=0
  - array contents = 0
- Reset asserted mid-operation discards all entries at once, without waiting for a clock edge.
- Write latency: data pushed at edge N is visible on L2 after edge N if the buffer was empty, and Valid rises after edge N.
- Pop: after the accepting edge, L2 shows the next entry. If that pop emptied the buffer, L2 shows 0 and Valid falls.
- Full, Valid and Count change only on CB edges or Reset; they are never combinational from inputs.
- Throughput: one push and one pop per cycle sustained at any occupancy, including full.
- Ovf rises on the edge following the dropped push.

## Test plan
- Reset with D=32'hFFFFFFFF, E1=1 held during Reset → L2=0, Count=0, Valid=0, Ovf=0. On the first edge after release, the push is accepted: Count=1, L2=32'hFFFFFFFF.
- Push 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444 (DEPTH=4) → Full=1, Count=4. Then pop four times → L2 sequence 11111111, 22222222, 33333333, 44444444, then 0, with Valid=0.
- Full, then push 32'hDEADBEEF with Rd=0 → entry dropped, Ovf=1, Count stays 4. Next cycle E1=1 and Rd=1 with D=32'h55555555 → Count stays 4, L2=32'h22222222. After draining, the last entry is 32'h55555555.
- Count=1 holding 32'hA, push 32'hB and pop in the same cycle → Count=1, L2=32'hB. Then pop on empty with Rd=1 → no change, Count=0.
- Count=3, assert Flush with E1=1 and Rd=1 → Count=0, Valid=0, Ovf=0, L2=0. Subsequent push of 32'h77 → L2=32'h77, which confirms the pointers restarted at 0.
- Parameter sweep WIDTH=8, DEPTH=2 and WIDTH=64, DEPTH=16 → 1000 cycles of random push/pop/flush traffic. All outputs match a scoreboard queue model, pointers wrap repeatedly without error, and Count never exceeds DEPTH.

Source files
------------

// File: rtl/p405s_icu_dp_fetchbuf.sv
// Enable-gated FIFO staging buffer between the ICU fill/fetch datapath and issue.
// Holds up to DEPTH words; reports occupancy and flags dropped pushes with a sticky Ovf.
module p405s_icu_dp_fetchbuf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CB,
  input  logic             Reset,
  input  logic [0:WIDTH-1] D,
  input  logic             E1,
  input  logic             Rd,
  input  logic             Flush,
  output logic [0:WIDTH-1] L2,
  output logic             Valid,
  output logic             Full,
  output logic [CW-1:0]    Count,
  output logic             Ovf
);

  localparam int PW = $clog2(DEPTH);

  // Handshake: E1 acts as a push-valid whose implicit ready is (~Full | pop accepted);
  // Rd acts as a pop-ready against Valid. A push is taken only when both sides agree,
  // and a refused push is not held -- it is dropped and recorded in Ovf.
  logic [0:WIDTH-1] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic w_valid;
  logic w_full;
  logic w_pa;
  logic w_wa;
  logic w_drop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pa    = Rd & w_valid;
  assign w_wa    = E1 & (~w_full | w_pa);
  assign w_drop  = E1 & w_full & ~w_pa;

  always_ff @(posedge CB or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wa && !Flush) begin
      r_mem[r_wp] <= D;
    end
  end

  // Flush outranks any push or pop presented in the same cycle.
  always_ff @(posedge CB or posedge Reset) begin
    if (Reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (Flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wa) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pa) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_wa, w_pa})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign L2    = w_valid ? r_mem[r_rp] : '0;
  assign Valid = w_valid;
  assign Full  = w_full;
  assign Count = r_count;
  assign Ovf   = r_ovf;

endmodule

// File: tb/tb_p405s_icu_dp_fetchbuf.sv
// Bench for p405s_icu_dp_fetchbuf: directed vector table on the default 32x4 buffer,
// an asynchronous mid-operation reset, and random traffic on 8x2 and 64x16 builds.
module tb_p405s_icu_dp_fetchbuf;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT1: WIDTH=32, DEPTH=4 ----------------
  logic [0:31] d1, l2_1;
  logic        e1_1, rd_1, fl_1, v_1, f_1, o_1;
  logic [2:0]  c_1;

  p405s_icu_dp_fetchbuf #(.WIDTH(32), .DEPTH(4)) u_dut1 (
    .CB(clk), .Reset(rst), .D(d1), .E1(e1_1), .Rd(rd_1), .Flush(fl_1),
    .L2(l2_1), .Valid(v_1), .Full(f_1), .Count(c_1), .Ovf(o_1)
  );

  // ---------------- DUT2: WIDTH=8, DEPTH=2 ----------------
  logic [0:7]  d2, l2_2;
  logic        e1_2, rd_2, fl_2, v_2, f_2, o_2;
  logic [1:0]  c_2;

  p405s_icu_dp_fetchbuf #(.WIDTH(8), .DEPTH(2)) u_dut2 (
    .CB(clk), .Reset(rst), .D(d2), .E1(e1_2), .Rd(rd_2), .Flush(fl_2),
    .L2(l2_2), .Valid(v_2), .Full(f_2), .Count(c_2), .Ovf(o_2)
  );

  // ---------------- DUT3: WIDTH=64, DEPTH=16 ----------------
  logic [0:63] d3, l2_3;
  logic        e1_3, rd_3, fl_3, v_3, f_3, o_3;
  logic [4:0]  c_3;

  p405s_icu_dp_fetchbuf #(.WIDTH(64), .DEPTH(16)) u_dut3 (
    .CB(clk), .Reset(rst), .D(d3), .E1(e1_3), .Rd(rd_3), .Flush(fl_3),
    .L2(l2_3), .Valid(v_3), .Full(f_3), .Count(c_3), .Ovf(o_3)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  exp_q2[$];
  logic [63:0] exp_q3[$];
  logic        exp_ovf2, exp_ovf3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_dut1(input string tag, input logic [31:0] l2, input int cnt, input logic ovf);
    chk({tag, "_l2"},    64'(l2_1), 64'(l2));
    chk({tag, "_count"}, 64'(c_1),  64'(cnt));
    chk({tag, "_valid"}, 64'(v_1),  64'(cnt != 0));
    chk({tag, "_full"},  64'(f_1),  64'(cnt == 4));
    chk({tag, "_ovf"},   64'(o_1),  64'(ovf));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        fl;
    logic        e1;
    logic        rd;
    logic [31:0] d;
    logic [31:0] l2;
    int          cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic av(input logic fl, input logic e1, input logic rd, input logic [31:0] d,
                    input logic [31:0] l2, input int cnt, input logic ovf);
    vec_t v;
    v.fl = fl; v.e1 = e1; v.rd = rd; v.d = d; v.l2 = l2; v.cnt = cnt; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  // ---------------- driver for random traffic ----------------
  task automatic drive_random(input int cyc);
    logic hi;
    logic pa, wa, full_now;
    hi = (cyc < 500);
    // DUT2
    e1_2 = hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
    rd_2 = hi ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
    fl_2 = ($urandom_range(0, 63) == 0);
    d2   = 8'($urandom);
    full_now = (exp_q2.size() == 2);
    pa = rd_2 && (exp_q2.size() != 0);
    wa = e1_2 && (!full_now || pa);
    if (fl_2) begin
      exp_q2.delete();
      exp_ovf2 = 1'b0;
    end else begin
      if (e1_2 && full_now && !pa) exp_ovf2 = 1'b1;
      if (pa) void'(exp_q2.pop_front());
      if (wa) exp_q2.push_back(d2);
    end
    // DUT3
    e1_3 = hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
    rd_3 = hi ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
    fl_3 = ($urandom_range(0, 127) == 0);
    d3   = {$urandom, $urandom};
    full_now = (exp_q3.size() == 16);
    pa = rd_3 && (exp_q3.size() != 0);
    wa = e1_3 && (!full_now || pa);
    if (fl_3) begin
      exp_q3.delete();
      exp_ovf3 = 1'b0;
    end else begin
      if (e1_3 && full_now && !pa) exp_ovf3 = 1'b1;
      if (pa) void'(exp_q3.pop_front());
      if (wa) exp_q3.push_back(d3);
    end
  endtask

  task automatic check_random();
    chk("r2_l2",    64'(l2_2), (exp_q2.size() != 0) ? 64'(exp_q2[0]) : 64'd0);
    chk("r2_count", 64'(c_2),  64'(exp_q2.size()));
    chk("r2_valid", 64'(v_2),  64'(exp_q2.size() != 0));
    chk("r2_full",  64'(f_2),  64'(exp_q2.size() == 2));
    chk("r2_ovf",   64'(o_2),  64'(exp_ovf2));
    chk("r2_bound", 64'(c_2 <= 2'd2), 64'd1);
    chk("r3_l2",    64'(l2_3), (exp_q3.size() != 0) ? exp_q3[0] : 64'd0);
    chk("r3_count", 64'(c_3),  64'(exp_q3.size()));
    chk("r3_valid", 64'(v_3),  64'(exp_q3.size() != 0));
    chk("r3_full",  64'(f_3),  64'(exp_q3.size() == 16));
    chk("r3_ovf",   64'(o_3),  64'(exp_ovf3));
    chk("r3_bound", 64'(c_3 <= 5'd16), 64'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    rst  = 1'b1;
    fl_1 = 1'b0; rd_1 = 1'b0; e1_1 = 1'b1; d1 = 32'hFFFF_FFFF;
    fl_2 = 1'b0; rd_2 = 1'b0; e1_2 = 1'b0; d2 = '0;
    fl_3 = 1'b0; rd_3 = 1'b0; e1_3 = 1'b0; d3 = '0;
    exp_ovf2 = 1'b0;
    exp_ovf3 = 1'b0;

    // Push held during reset is ignored; first edge after release accepts it.
    repeat (2) @(posedge clk);
    #1;
    chk_dut1("rst", 32'h0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_dut1("rst_rel", 32'hFFFF_FFFF, 1, 1'b0);

    //  fl    e1    rd    d              exp_l2         cnt ovf
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         0, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h1111_1111, 1, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'h2222_2222, 32'h1111_1111, 2, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'h3333_3333, 32'h1111_1111, 3, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'h4444_4444, 32'h1111_1111, 4, 1'b0);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h2222_2222, 3, 1'b0);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h3333_3333, 2, 1'b0);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h4444_4444, 1, 1'b0);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         0, 1'b0);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         0, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h1111_1111, 1, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'h2222_2222, 32'h1111_1111, 2, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'h3333_3333, 32'h1111_1111, 3, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'h4444_4444, 32'h1111_1111, 4, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 4, 1'b1);
    av(1'b0, 1'b1, 1'b1, 32'h5555_5555, 32'h2222_2222, 4, 1'b1);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h3333_3333, 3, 1'b1);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h4444_4444, 2, 1'b1);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h5555_5555, 1, 1'b1);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         0, 1'b1);
    av(1'b0, 1'b1, 1'b0, 32'hA,         32'hA,         1, 1'b1);
    av(1'b0, 1'b1, 1'b1, 32'hB,         32'hB,         1, 1'b1);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         0, 1'b1);
    av(1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         0, 1'b1);
    av(1'b0, 1'b1, 1'b0, 32'h1,         32'h1,         1, 1'b1);
    av(1'b0, 1'b1, 1'b0, 32'h2,         32'h1,         2, 1'b1);
    av(1'b0, 1'b1, 1'b0, 32'h3,         32'h1,         3, 1'b1);
    av(1'b1, 1'b1, 1'b1, 32'h99,        32'h0,         0, 1'b0);
    av(1'b0, 1'b1, 1'b0, 32'h77,        32'h77,        1, 1'b0);
    av(1'b0, 1'b1, 1'b1, 32'h88,        32'h88,        1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      fl_1 = vecs[i].fl;
      e1_1 = vecs[i].e1;
      rd_1 = vecs[i].rd;
      d1   = vecs[i].d;
      @(posedge clk);
      #1;
      chk_dut1($sformatf("v%0d", i), vecs[i].l2, vecs[i].cnt, vecs[i].ovf);
    end

    // Asynchronous reset mid-operation: entries vanish before any clock edge.
    @(negedge clk);
    fl_1 = 1'b0; rd_1 = 1'b0; e1_1 = 1'b1; d1 = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    chk_dut1("pre_arst", 32'h88, 2, 1'b0);
    @(negedge clk);
    e1_1 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_dut1("arst", 32'h0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_dut1("arst_rel", 32'h0, 0, 1'b0);

    // Random push/pop/flush traffic against queue models.
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      drive_random(cyc);
      @(posedge clk);
      #1;
      check_random();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
